// File: rtl/button_conditioner.sv
// Push-button front-end: per-channel two-flop synchronizer, stability-count
// debouncer and rising-edge one-shot. Each bit of btn_raw is an independent
// channel. Define AUTO_REPEAT_EN to add a per-channel auto-repeat counter
// that re-fires btn_pulse every REPEAT_CYCLES cycles while a button is held.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntInc = CntW'(1);

  // Both counts must be at least one cycle.
  if (DEBOUNCE_CYCLES == 0 || REPEAT_CYCLES == 0) begin : gen_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic [NUM_BTN-1:0] s1_q, s2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic [CntW-1:0]    cnt_q [NUM_BTN];
  logic [CntW-1:0]    cnt_d [NUM_BTN];

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RptW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RptW-1:0] RptMax = RptW'(REPEAT_CYCLES - 1);
  localparam logic [RptW-1:0] RptInc = RptW'(1);

  logic [RptW-1:0] rpt_q [NUM_BTN];
  logic [RptW-1:0] rpt_d [NUM_BTN];
`endif

  // Debounce, one-shot and (optional) repeat next-state per channel.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = cnt_q[i];
      // A sample agreeing with the current level restarts qualification.
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntInc;
      end
      pulse_d[i] = level_d[i] & ~level_q[i];
`ifdef AUTO_REPEAT_EN
      rpt_d[i] = '0;
      // Only count while the button stays held; a release edge stops repeats.
      if (level_q[i] && level_d[i]) begin
        if (rpt_q[i] == RptMax) begin
          pulse_d[i] = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + RptInc;
        end
      end
`endif
    end
  end

  // State registers; synchronous reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
`ifdef AUTO_REPEAT_EN
        rpt_q[i] <= '0;
`endif
      end
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
`ifdef AUTO_REPEAT_EN
        rpt_q[i] <= rpt_d[i];
`endif
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the board push-buttons. It conditions raw, asynchronous, bouncing button inputs into clean signals for the downstream display/state FSM.
- Per button it provides a two-flop synchronizer, a stability-count debouncer and a rising-edge one-shot.
- Outputs are a debounced level and a single-cycle press pulse per button. The downstream FSM consumes only the pulses, so one physical press causes exactly one state transition.

Parameters:
- NUM_BTN, 3, number of buttons. Bit mapping: bit0 = up, bit1 = left, bit2 = right.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a change (10 ms at 100 MHz). Must be >= 1.
- REPEAT_CYCLES, 25000000, auto-repeat period in cycles. Used only when AUTO_REPEAT_EN is defined. Must be >= 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- btn_raw  input  NUM_BTN  raw pad inputs, asynchronous, active-high
- btn_level  output  NUM_BTN  debounced button state, registered
- btn_pulse  output  NUM_BTN  one-cycle press strobe, registered

Behaviour:
- Interface (already decided): reset is reset, synchronous, active-high; clock is clk.
- Reset, sampled at a clk edge with reset = 1:
  - sync flops, counters, btn_level and btn_pulse all cleared to 0.
  - Effective on the same edge; reset has priority over all other logic.
- Channel independence: each bit is a fully independent channel with no shared state or arbitration.
  - Several btn_pulse bits may assert in the same cycle; downstream priority is the consumer's concern.
- Synchronizer: s1 <= btn_raw[i]; s2 <= s1. Only s2 feeds the debouncer.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)), evaluated each edge:
  - s2 == btn_level[i]: cnt <= 0.
  - s2 != btn_level[i] and cnt == DEBOUNCE_CYCLES-1: btn_level[i] <= s2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Bounce rejection: any sample agreeing with the current level restarts the count. A glitch shorter than DEBOUNCE_CYCLES+... never changes btn_level.
- Latency: with btn_raw first sampled high at edge k and held, btn_level rises after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges. Release behaves symmetrically.
- Press pulse: btn_pulse[i] is high for exactly the one cycle following the edge where btn_level[i] goes 0->1.
  - No pulse on release.
  - No pulse while the button is held (unless AUTO_REPEAT_EN is defined).
- Per-channel states, implementation may encode them implicitly:
  - RELEASED (level 0, cnt 0) -> PRESS_PEND on s2 = 1.
  - PRESS_PEND -> RELEASED when s2 = 0. PRESS_PEND -> PRESSED when the count completes; btn_pulse fires.
  - PRESSED -> REL_PEND on s2 = 0.
  - REL_PEND -> PRESSED when s2 = 1. REL_PEND -> RELEASED when the count completes.
- Reset mid-operation: all state is discarded. A button held through reset is re-qualified from RELEASED and produces one press pulse DEBOUNCE_CYCLES+2 edges after the first edge with reset low.
- No pulse is ever emitted during or on the edge of reset.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: each channel gets a repeat counter, cleared whenever btn_level[i] = 0 and on the press edge.
  - While btn_level[i] = 1, the counter increments each cycle.
  - On reaching REPEAT_CYCLES-1, btn_pulse[i] fires for one cycle and the counter clears.
  - Result while held: pulses occur every REPEAT_CYCLES cycles after the initial press pulse.
  - Release immediately stops further pulses. Reset clears the counter.
- Not defined: no repeat logic is synthesized, and exactly one pulse is produced per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, NUM_BTN=3):
- Reset/idle: hold reset 3 cycles with btn_raw=3'b111, then release reset. btn_level=0 and btn_pulse=0 during reset. btn_level=3'b111 and btn_pulse=3'b111 for one cycle, 6 edges after reset deasserts.
- Clean press: btn_raw[0] 0->1 held 20 cycles. btn_level[0] rises 6 edges after first high sample, with one pulse on bit 0. Release gives btn_level[0]=0 6 edges later and no pulse.
- Bounce: btn_raw[1] toggles 1,0,1,1,0,1 then holds high. Level rises only after 4 consecutive synced highs, with exactly one pulse total.
- Short glitch: btn_raw[2] high for 3 cycles, then low. btn_level[2] and btn_pulse[2] stay 0 throughout.
- Simultaneous: bits 1 and 2 rise on the same edge. btn_pulse=3'b110 in one cycle; bit 0 is unaffected.
- AUTO_REPEAT_EN: hold btn_raw[0] 40 cycles. The initial pulse is followed by repeat pulses every 8 cycles while held, with none after release. Same stimulus without the macro yields a single pulse.
